// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
//   Shared types and helpers for the SAR conversion scheduler.
//
//   Contents:
//     BIT_ADC_DEF  default SAR result width
//     RR_MAX_CH    largest channel count the round-robin helper supports
//     sar_state_e  scheduler FSM state encoding
//     rr_next_ch() round-robin next-channel search over an enable mask
// ---------------------------------------------------------------------------
package sar_pkg;

  localparam int BIT_ADC_DEF = 6;
  localparam int RR_MAX_CH   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_START   = 3'd3,
    ST_CONVERT = 3'd4,
    ST_ACCUM   = 3'd5,
    ST_OUTPUT  = 3'd6
  } sar_state_e;

  // Returns the first enabled channel found by searching upward from
  // (cur + 1) mod n_ch with wrap-around. The last candidate examined is cur
  // itself, so a single enabled channel picks itself again. With an empty
  // mask the result is cur (callers gate on the mask being non-zero).
  // The loop runs downward so that the smallest offset is the last writer.
  function automatic int rr_next_ch(input int cur,
                                    input logic [RR_MAX_CH-1:0] mask,
                                    input int n_ch);
    int pick;
    int idx;
    pick = cur;
    for (int k = RR_MAX_CH; k >= 1; k--) begin
      if (k <= n_ch) begin
        idx = cur + k;
        if (idx >= n_ch) begin
          idx = idx - n_ch;
        end
        if (mask[idx[3:0]]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sar_rr_pick.sv
// ---------------------------------------------------------------------------
// sar_rr_pick
//   Combinational round-robin channel finder. Given the current channel and
//   an enable mask it returns the next enabled channel above the current one
//   (wrapping), falling back to the current channel when it is the only one
//   enabled.
//
//   Parameters:
//     N_CH  number of channels (2..16)
//     CH_W  channel index width, clog2(N_CH)
//   Ports:
//     cur_ch   in   CH_W  channel the search starts after
//     mask     in   N_CH  enable mask, bit i = channel i
//     next_ch  out  CH_W  picked channel
//     any_en   out  1     at least one channel enabled
// ---------------------------------------------------------------------------
module sar_rr_pick
  import sar_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [CH_W-1:0] cur_ch,
  input  logic [N_CH-1:0] mask,
  output logic [CH_W-1:0] next_ch,
  output logic            any_en
);

  logic [RR_MAX_CH-1:0] mask_ext;

  always_comb begin
    mask_ext            = '0;
    mask_ext[N_CH-1:0]  = mask;
  end

  assign next_ch = CH_W'(rr_next_ch(int'(cur_ch), mask_ext, N_CH));
  assign any_en  = |mask;

endmodule

// File: rtl/sar_conv_scheduler.sv
// ---------------------------------------------------------------------------
// sar_conv_scheduler
//   Multi-channel conversion sequencer for the SAR ADC. Scans the enabled mux
//   channels round-robin, waits a programmable settle time after every mux
//   switch, fires a one-cycle active-low start pulse at the SAR logic, waits
//   for a rising EOC and averages 2^AVG_LOG2 samples per channel. Each
//   averaged result is presented with a one-cycle RESULT_VALID pulse.
//
//   Handshake: there is no back-pressure. RESULT_VALID is high for exactly
//   one cycle per result; RESULT_CH/RESULT_DATA are valid in that cycle and
//   hold until the next result. SAR_XRST low for one cycle requests one
//   conversion; a low-to-high transition of SAR_EOC marks it complete, with
//   SAR_DOUT valid in the cycle EOC is first seen high.
//
//   Ports:
//     CLK, XRST     clock, synchronous active-low reset
//     EN            scan enable (level)
//     CH_MASK       channel enable mask, sampled in SELECT only
//     SETTLE_CYC    settle cycles after a mux change (0 = one pass-through)
//     MUX_SEL       analog mux select (registered)
//     SAR_XRST      start pulse to the SAR logic, low in START only
//     SAR_EOC       end of conversion from the SAR logic
//     SAR_DOUT      SAR result
//     RESULT_VALID  one-cycle pulse: averaged result ready
//     RESULT_CH     channel of the result
//     RESULT_DATA   averaged (truncated) result
//     BUSY          FSM not in IDLE
//     ERR_TIMEOUT   sticky EOC-timeout flag, cleared only by reset
//
//   All outputs are flops loaded from the next-state decode, so each output
//   changes in the same cycle as the state it belongs to.
// ---------------------------------------------------------------------------
module sar_conv_scheduler
  import sar_pkg::*;
#(
  parameter int BIT_ADC     = BIT_ADC_DEF,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int AVG_LOG2    = 2,
  parameter int SETTLE_W    = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                CLK,
  input  logic                XRST,
  input  logic                EN,
  input  logic [N_CH-1:0]     CH_MASK,
  input  logic [SETTLE_W-1:0] SETTLE_CYC,
  output logic [CH_W-1:0]     MUX_SEL,
  output logic                SAR_XRST,
  input  logic                SAR_EOC,
  input  logic [BIT_ADC-1:0]  SAR_DOUT,
  output logic                RESULT_VALID,
  output logic [CH_W-1:0]     RESULT_CH,
  output logic [BIT_ADC-1:0]  RESULT_DATA,
  output logic                BUSY,
  output logic                ERR_TIMEOUT
);

  localparam int ACC_W = BIT_ADC + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]    N_SAMPLES  = CNT_W'(2 ** AVG_LOG2);
  // The timer holds the number of cycles elapsed since the start pulse
  // cycle. Flagging at TIMEOUT_CYC-1 makes ERR_TIMEOUT (a flop) visible
  // exactly TIMEOUT_CYC cycles after the start pulse.
  localparam logic [TMR_W-1:0]    TMR_LIMIT  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]    TMR_ONE    = TMR_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

  // State and datapath registers
  sar_state_e          state_q, state_d;
  logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                eoc_prev_q, eoc_prev_d;
  // Set by reset: the first channel search starts at channel 0 and the first
  // selection is treated as a mux change, since the analog mux state is not
  // known to have settled.
  logic                first_q, first_d;

  // Registered outputs
  logic                sar_xrst_q, sar_xrst_d;
  logic                result_valid_q, result_valid_d;
  logic [CH_W-1:0]     result_ch_q, result_ch_d;
  logic [BIT_ADC-1:0]  result_data_q, result_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Round-robin pick
  logic [CH_W-1:0]     search_from;
  logic [CH_W-1:0]     pick_ch;
  logic                any_en;
  logic                eoc_rise;

  // Searching "after N_CH-1" wraps to channel 0 as the first candidate.
  assign search_from = first_q ? CH_W'(N_CH - 1) : mux_sel_q;

  sar_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .cur_ch  (search_from),
    .mask    (CH_MASK),
    .next_ch (pick_ch),
    .any_en  (any_en)
  );

  // EOC that was already high before CONVERT never produces a rise here.
  assign eoc_rise = SAR_EOC & ~eoc_prev_q;

  always_comb begin
    state_d       = state_q;
    mux_sel_d     = mux_sel_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    settle_d      = settle_q;
    eoc_prev_d    = SAR_EOC;
    first_d       = first_q;
    result_ch_d   = result_ch_q;
    result_data_d = result_data_q;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (EN && any_en) begin
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!EN || !any_en) begin
          state_d = ST_IDLE;
        end else begin
          mux_sel_d = pick_ch;
          acc_d     = '0;
          cnt_d     = '0;
          settle_d  = SETTLE_CYC;
          first_d   = 1'b0;
          // A single enabled channel keeps the mux where it is: no settle.
          if ((pick_ch == mux_sel_q) && !first_q) begin
            state_d = ST_START;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        // Counts SETTLE_CYC cycles; 0 and 1 both take a single cycle.
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (settle_q <= SETTLE_ONE) begin
          state_d = ST_START;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end

      ST_START: begin
        tmr_d   = TMR_ONE;
        state_d = ST_CONVERT;
      end

      ST_CONVERT: begin
        if (eoc_rise) begin
          acc_d   = acc_q + ACC_W'(SAR_DOUT);
          state_d = ST_ACCUM;
        end else if (tmr_q == TMR_LIMIT) begin
          // Abandon the channel: its partial accumulation is discarded.
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = EN ? ST_SELECT : ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      ST_ACCUM: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_d == N_SAMPLES) begin
          state_d       = ST_OUTPUT;
          result_data_d = acc_q[ACC_W-1:AVG_LOG2];
          result_ch_d   = mux_sel_q;
        end else if (!EN) begin
          // Partial average is dropped; nothing is reported.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end

      ST_OUTPUT: begin
        state_d = EN ? ST_SELECT : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sar_xrst_d     = (state_d != ST_START);
    result_valid_d = (state_d == ST_OUTPUT);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      state_q        <= ST_IDLE;
      mux_sel_q      <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      tmr_q          <= '0;
      settle_q       <= '0;
      eoc_prev_q     <= 1'b0;
      first_q        <= 1'b1;
      sar_xrst_q     <= 1'b1;
      result_valid_q <= 1'b0;
      result_ch_q    <= '0;
      result_data_q  <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mux_sel_q      <= mux_sel_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      tmr_q          <= tmr_d;
      settle_q       <= settle_d;
      eoc_prev_q     <= eoc_prev_d;
      first_q        <= first_d;
      sar_xrst_q     <= sar_xrst_d;
      result_valid_q <= result_valid_d;
      result_ch_q    <= result_ch_d;
      result_data_q  <= result_data_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign MUX_SEL      = mux_sel_q;
  assign SAR_XRST     = sar_xrst_q;
  assign RESULT_VALID = result_valid_q;
  assign RESULT_CH    = result_ch_q;
  assign RESULT_DATA  = result_data_q;
  assign BUSY         = busy_q;
  assign ERR_TIMEOUT  = err_q;

endmodule
